// File: rtl/prbs7_checker.sv
// PRBS7 (x^7 + x^6 + 1) receive-side checker.
// Hunts for seven non-zero received bits, verifies LOCK_CNT consecutive
// self-predicted bits, then locks a free-running local LFSR and counts
// mismatches. Too many mismatches inside one WINDOW drops lock.
// Handshake: a bit on prbs_i is consumed only in a cycle where valid_i=1;
// there is no back-pressure, and with valid_i=0 all state holds.
module prbs7_checker #(
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 prbs_i,
    input  logic                 valid_i,
    input  logic                 clear_i,
    input  logic                 resync_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic [1:0]           state_o
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
    localparam int unsigned ERRS_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [MATCH_W-1:0]   MATCH_LOCK  = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]     WIN_FULL    = WIN_W'(WINDOW);
    localparam logic [ERRS_W-1:0]    ERRS_UNLOCK = ERRS_W'(UNLOCK_ERRS);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [6:0]           hist_q, hist_d;
    logic [6:0]           lfsr_q, lfsr_d;
    logic [2:0]           fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WIN_W-1:0]     win_bits_q, win_bits_d;
    logic [ERRS_W-1:0]    win_errs_q, win_errs_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    // Derived per-bit quantities shared by the next-state logic.
    logic [6:0]         hist_shift;
    logic [2:0]         fill_next;
    logic               pred_hist;
    logic               pred_lfsr;
    logic               bit_err;
    logic [MATCH_W-1:0] match_inc;
    logic [WIN_W-1:0]   bits_inc;
    logic [ERRS_W-1:0]  errs_new;

    // Predictions from the received history and the local LFSR, plus counter increments.
    always_comb begin
        hist_shift = {hist_q[5:0], prbs_i};
        fill_next  = (fill_q == 3'd7) ? 3'd7 : fill_q + 3'd1;
        pred_hist  = hist_q[6] ^ hist_q[5];
        pred_lfsr  = lfsr_q[6] ^ lfsr_q[5];
        bit_err    = prbs_i ^ pred_lfsr;
        match_inc  = match_q + MATCH_W'(1);
        bits_inc   = win_bits_q + WIN_W'(1);
        errs_new   = bit_err ? win_errs_q + ERRS_W'(1) : win_errs_q;
    end

    // Next-state logic: resync beats bit processing, clear beats a same-cycle count increment.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        lfsr_d      = lfsr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;

        if (resync_i) begin
            state_d    = ST_HUNT;
            hist_d     = '0;
            fill_d     = '0;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
        end else if (valid_i) begin
            unique case (state_q)
                ST_HUNT: begin
                    hist_d = hist_shift;
                    fill_d = fill_next;
                    // An all-zero history is the PRBS lock-up state, never a valid seed.
                    if ((fill_next == 3'd7) && (hist_shift != 7'd0)) begin
                        state_d = ST_VERIFY;
                        match_d = '0;
                    end
                end
                ST_VERIFY: begin
                    hist_d  = hist_shift;
                    match_d = (prbs_i == pred_hist) ? match_inc : '0;
                    if (hist_shift == 7'd0) begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                    end else if ((prbs_i == pred_hist) && (match_inc == MATCH_LOCK)) begin
                        state_d    = ST_LOCKED;
                        lfsr_d     = hist_shift;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // The LFSR feeds back its own prediction, so a single line error
                    // cannot propagate into later predictions.
                    lfsr_d = {lfsr_q[5:0], pred_lfsr};
                    if (bit_err) begin
                        err_d = 1'b1;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_CNT_W'(1);
                        end
                    end
                    if (errs_new == ERRS_UNLOCK) begin
                        state_d    = ST_HUNT;
                        fill_d     = '0;
                        hist_d     = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else if (bits_inc == WIN_FULL) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = bits_inc;
                        win_errs_d = errs_new;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
        end

        if (clear_i) begin
            err_count_d = '0;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HUNT;
            hist_q      <= '0;
            lfsr_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            lfsr_q      <= lfsr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;
    assign state_o     = state_q;

endmodule
